// File: rtl/cruise_limit_sched.sv
// cruise_limit_sched
//   Arbitrates road-sign and driver speed requests into a single speed cap and
//   drives the controller's speed_limit. Lowering is immediate; raising ramps
//   in STEP-sized increments every RAMP_DIV cycles. Cancel forces the limit to
//   0 until released, after which the ramp restarts from 0.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   sign_valid/limit   road-sign request, sign_ready handshake
//   drv_valid/speed    driver set-speed request (0 = clear), drv_ready handshake
//   cancel             level-sensitive brake/cancel
//   speed_limit        registered limit output
//   limit_target       combinational min(sign_cap, drv_cap)
//   ramp_busy          high while ramping upward
//   sat_err            one-cycle pulse after a clamped accepted request
module cruise_limit_sched #(
  parameter int unsigned RAMP_DIV      = 4,
  parameter logic [7:0]  STEP          = 8'd2,
  parameter logic [7:0]  MAX_LIMIT     = 8'd130,
  parameter logic [7:0]  DEFAULT_LIMIT = 8'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sign_valid,
  input  logic [7:0] sign_limit,
  output logic       sign_ready,
  input  logic       drv_valid,
  input  logic [7:0] drv_speed,
  output logic       drv_ready,
  input  logic       cancel,
  output logic [7:0] speed_limit,
  output logic [7:0] limit_target,
  output logic       ramp_busy,
  output logic       sat_err
);
  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {IDLE, RAMP, CANCEL} state_t;

  state_t        state;
  logic [7:0]    sign_cap, drv_cap;
  logic [CW-1:0] tick;

  logic       sign_acc, drv_acc, sat_nxt;
  logic [7:0] sign_clamp, drv_clamp, diff, step_amt, stepped;

  // Sign wins a same-cycle conflict; the driver must hold its request.
  assign sign_ready = ~cancel;
  assign drv_ready  = ~cancel & ~sign_valid;
  assign sign_acc   = sign_valid & sign_ready;
  assign drv_acc    = drv_valid & drv_ready;

  assign limit_target = (sign_cap < drv_cap) ? sign_cap : drv_cap;
  assign ramp_busy    = (state == RAMP);

  always_comb begin
    sign_clamp = (sign_limit > MAX_LIMIT) ? MAX_LIMIT : sign_limit;
    // Zero means "no driver cap", which is the same as the ceiling.
    if (drv_speed == 8'd0)          drv_clamp = MAX_LIMIT;
    else if (drv_speed > MAX_LIMIT) drv_clamp = MAX_LIMIT;
    else                            drv_clamp = drv_speed;
    sat_nxt = (sign_acc & (sign_limit > MAX_LIMIT)) |
              (drv_acc  & (drv_speed  > MAX_LIMIT));
    // Difference only formed when the target is above, so it never wraps.
    diff     = (limit_target > speed_limit) ? (limit_target - speed_limit) : 8'd0;
    step_amt = (diff < STEP) ? diff : STEP;
    stepped  = speed_limit + step_amt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      speed_limit <= 8'd0;
      sign_cap    <= DEFAULT_LIMIT;
      drv_cap     <= MAX_LIMIT;
      tick        <= '0;
      sat_err     <= 1'b0;
    end else begin
      sat_err <= sat_nxt;
      if (sign_acc) sign_cap <= sign_clamp;
      if (drv_acc)  drv_cap  <= drv_clamp;

      if (cancel) begin
        state       <= CANCEL;
        speed_limit <= 8'd0;
      end else begin
        unique case (state)
          IDLE: begin
            if (limit_target < speed_limit) begin
              speed_limit <= limit_target;
            end else if (limit_target > speed_limit) begin
              state <= RAMP;
              tick  <= '0;
            end
          end
          RAMP: begin
            if (limit_target < speed_limit) begin
              speed_limit <= limit_target;
              state       <= IDLE;
            end else if (limit_target == speed_limit) begin
              // Target lowered exactly onto the current limit: nothing left to do.
              state <= IDLE;
            end else if (tick == TICK_LAST) begin
              speed_limit <= stepped;
              tick        <= '0;
              if (stepped == limit_target) state <= IDLE;
            end else begin
              tick <= tick + CW'(1);
            end
          end
          CANCEL: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cruise_limit_sched.sv
module tb_cruise_limit_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sign_valid = 1'b0;
  logic [7:0] sign_limit = 8'd0;
  logic       sign_ready;
  logic       drv_valid = 1'b0;
  logic [7:0] drv_speed = 8'd0;
  logic       drv_ready;
  logic       cancel = 1'b0;
  logic [7:0] speed_limit, limit_target;
  logic       ramp_busy, sat_err;

  cruise_limit_sched dut (
    .clk(clk), .rst(rst),
    .sign_valid(sign_valid), .sign_limit(sign_limit), .sign_ready(sign_ready),
    .drv_valid(drv_valid), .drv_speed(drv_speed), .drv_ready(drv_ready),
    .cancel(cancel), .speed_limit(speed_limit), .limit_target(limit_target),
    .ramp_busy(ramp_busy), .sat_err(sat_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] val; } sev_t;
  sev_t sq[$];
  int   satq[$];
  int   total = 0, bad = 0;
  bit   mon_en = 1'b0;
  logic [7:0] prev = 8'd0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  // Expect n ramp steps: edge start+4k carries base+2k.
  task automatic push_ramp(input int start, input int base, input int n);
    for (int k = 1; k <= n; k++) begin
      sev_t e;
      e.cyc = start + 4 * k;
      e.val = 8'(base + 2 * k);
      sq.push_back(e);
    end
  endtask

  task automatic push_one(input int c, input int v);
    sev_t e;
    e.cyc = c;
    e.val = 8'(v);
    sq.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of speed_limit and every sat_err pulse is matched
  // against the scoreboard queues, including the cycle it happened on.
  always @(negedge clk) begin
    if (mon_en) begin
      if (speed_limit !== prev) begin
        total++;
        if (sq.size() == 0) begin
          bad++;
          $display("FAIL speed_unexp: got %0d at cyc %0d, none expected", speed_limit, cyc);
        end else begin
          sev_t e;
          e = sq.pop_front();
          if (e.cyc != cyc || e.val !== speed_limit) begin
            bad++;
            $display("FAIL speed_step: got %0d at cyc %0d want %0d at cyc %0d",
                     speed_limit, cyc, e.val, e.cyc);
          end
        end
        prev = speed_limit;
      end else if (sq.size() != 0 && sq[0].cyc < cyc) begin
        sev_t e;
        e = sq.pop_front();
        total++; bad++;
        $display("FAIL speed_missed: got %0d want %0d at cyc %0d", speed_limit, e.val, e.cyc);
      end
      if (sat_err === 1'b1) begin
        total++;
        if (satq.size() == 0) begin
          bad++;
          $display("FAIL sat_unexp: got 1 at cyc %0d want 0", cyc);
        end else begin
          int c;
          c = satq.pop_front();
          if (c != cyc) begin
            bad++;
            $display("FAIL sat_cyc: pulse at cyc %0d want cyc %0d", cyc, c);
          end
        end
      end else if (satq.size() != 0 && satq[0] < cyc) begin
        int c;
        c = satq.pop_front();
        total++; bad++;
        $display("FAIL sat_missed: got 0 want pulse at cyc %0d", c);
      end
    end
  end

  initial begin
    int c;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_speed", speed_limit, 0);
    chk("rst_busy", ramp_busy, 0);
    chk("rst_target", limit_target, 50);
    chk("rst_sat", sat_err, 0);
    chk("rst_sready", sign_ready, 1);
    chk("rst_dready", drv_ready, 1);

    // Default ramp 0 -> 50: RAMP entry on first edge, steps every 4 cycles
    c = cyc;
    prev = 8'd0;
    mon_en = 1'b1;
    push_ramp(c + 1, 0, 25);
    rst = 1'b0;
    wait_until(c + 50);
    chk("ramp_busy_mid", ramp_busy, 1);
    wait_until(c + 101);
    chk("ramp50_speed", speed_limit, 50);
    chk("ramp50_busy", ramp_busy, 0);
    repeat (4) @(negedge clk);

    // Sign 30 below current limit: drop one cycle after acceptance
    c = cyc;
    sign_valid = 1'b1; sign_limit = 8'd30;
    #1 chk("s30_ready", sign_ready, 1);
    push_one(c + 2, 30);
    @(negedge clk);
    sign_valid = 1'b0;
    @(negedge clk);
    chk("s30_busy", ramp_busy, 0);
    chk("s30_target", limit_target, 30);
    repeat (4) @(negedge clk);

    // Same-cycle conflict: sign 100 wins, driver 80 accepted next cycle
    c = cyc;
    sign_valid = 1'b1; sign_limit = 8'd100;
    drv_valid  = 1'b1; drv_speed  = 8'd80;
    #1 chk("conf_sready", sign_ready, 1);
    chk("conf_dready", drv_ready, 0);
    push_ramp(c + 2, 30, 25);
    @(negedge clk);
    sign_valid = 1'b0;
    #1 chk("conf_dready2", drv_ready, 1);
    @(negedge clk);
    drv_valid = 1'b0;
    chk("conf_target", limit_target, 80);
    chk("conf_busy", ramp_busy, 1);
    wait_until(c + 102);
    chk("ramp80_speed", speed_limit, 80);
    chk("ramp80_busy", ramp_busy, 0);
    repeat (4) @(negedge clk);

    // Driver 0 clears cap (target 100), then driver 200 clamps with sat pulse
    c = cyc;
    drv_valid = 1'b1; drv_speed = 8'd0;
    #1 chk("d0_ready", drv_ready, 1);
    push_ramp(c + 2, 80, 10);
    satq.push_back(c + 2);
    @(negedge clk);
    drv_speed = 8'd200;
    #1 chk("d0_target", limit_target, 100);
    @(negedge clk);
    drv_valid = 1'b0;
    chk("d200_target", limit_target, 100);
    wait_until(c + 42);
    chk("ramp100_speed", speed_limit, 100);
    repeat (4) @(negedge clk);

    // Sign 80 drops limit to 80
    c = cyc;
    sign_valid = 1'b1; sign_limit = 8'd80;
    push_one(c + 2, 80);
    @(negedge clk);
    sign_valid = 1'b0;
    @(negedge clk);
    chk("s80_target", limit_target, 80);
    repeat (2) @(negedge clk);

    // Cancel from idle: requests blocked, caps retained
    c = cyc;
    cancel = 1'b1;
    push_one(c + 1, 0);
    @(negedge clk);
    sign_valid = 1'b1; sign_limit = 8'd10;
    drv_valid  = 1'b1; drv_speed  = 8'd10;
    #1 chk("can_sready", sign_ready, 0);
    chk("can_dready", drv_ready, 0);
    repeat (2) @(negedge clk);
    chk("can_target", limit_target, 80);
    chk("can_busy", ramp_busy, 0);

    // Release: ramp from 0 toward 80, cancel again when at 20
    c = cyc;
    cancel = 1'b0; sign_valid = 1'b0; drv_valid = 1'b0;
    push_ramp(c + 2, 0, 10);
    wait_until(c + 42);
    chk("at20_busy", ramp_busy, 1);
    cancel = 1'b1;
    push_one(c + 43, 0);
    @(negedge clk);
    chk("can2_sready", sign_ready, 0);
    chk("can2_dready", drv_ready, 0);
    chk("can2_busy", ramp_busy, 0);
    repeat (2) @(negedge clk);

    // Release again; reset when the ramp reaches 40
    c = cyc;
    cancel = 1'b0;
    push_ramp(c + 2, 0, 20);
    wait_until(c + 82);
    rst = 1'b1;
    sign_valid = 1'b1; sign_limit = 8'd10;
    push_one(c + 83, 0);
    @(negedge clk);
    chk("rst2_target", limit_target, 50);
    chk("rst2_busy", ramp_busy, 0);
    chk("rst2_sat", sat_err, 0);

    // After release, first step lands 4 cycles after RAMP entry
    c = cyc;
    rst = 1'b0; sign_valid = 1'b0;
    push_ramp(c + 1, 0, 1);
    wait_until(c + 6);
    chk("rst2_step", speed_limit, 2);
    chk("sq_empty", sq.size(), 0);
    chk("satq_empty", satq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
